// File: rtl/booth10_prod_accum.sv
// booth10_prod_accum: frame accumulator for the Booth multiplier's signed
// product stream. Sums len beats into a saturating accumulator and offers
// one result per frame on a valid/ready output.
module booth10_prod_accum #(
  parameter int unsigned P_W   = 20,
  parameter int unsigned ACC_W = 24,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [P_W-1:0]   in_p,
  input  logic [LEN_W-1:0] len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  w_acc_nxt;
  logic [LEN_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  w_cnt_nxt;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  w_len_nxt;
  logic              r_ovf;
  logic              w_ovf_nxt;
  logic [ACC_W-1:0]  r_out_acc;
  logic [ACC_W-1:0]  w_out_acc_nxt;
  logic              r_out_ovf;
  logic              w_out_ovf_nxt;

  logic              w_beat;
  logic [ACC_W:0]    w_p_ext;
  logic [ACC_W:0]    w_base;
  logic [ACC_W:0]    w_sum;
  logic              w_pos_clamp;
  logic              w_neg_clamp;
  logic              w_sat_flag;
  logic [ACC_W-1:0]  w_sat_val;
  logic [LEN_W-1:0]  w_len_eff;
  logic [LEN_W-1:0]  w_cnt_inc;

  // Saturating adder: operands both fit ACC_W, so one guard bit exposes overflow.
  // in_p is masked when not valid so an X on the bus never reaches state.
  always_comb begin
    w_p_ext     = '0;
    if (in_valid)
      w_p_ext = {{(ACC_W+1-P_W){in_p[P_W-1]}}, in_p};
    w_base      = (r_state == S_ACCUM) ? {r_acc[ACC_W-1], r_acc} : '0;
    w_sum       = w_base + w_p_ext;
    w_pos_clamp = ~w_sum[ACC_W] &  w_sum[ACC_W-1];
    w_neg_clamp =  w_sum[ACC_W] & ~w_sum[ACC_W-1];
    w_sat_flag  = w_pos_clamp | w_neg_clamp;
    if (w_pos_clamp)
      w_sat_val = ACC_MAX;
    else if (w_neg_clamp)
      w_sat_val = ACC_MIN;
    else
      w_sat_val = w_sum[ACC_W-1:0];
  end

  // Next-state and datapath updates for the IDLE/ACCUM/HOLD frame sequencer.
  always_comb begin
    w_state_nxt   = r_state;
    w_acc_nxt     = r_acc;
    w_cnt_nxt     = r_cnt;
    w_len_nxt     = r_len;
    w_ovf_nxt     = r_ovf;
    w_out_acc_nxt = r_out_acc;
    w_out_ovf_nxt = r_out_ovf;
    in_ready      = (r_state != S_HOLD);
    out_valid     = (r_state == S_HOLD);
    busy          = (r_state != S_IDLE);
    w_beat        = in_valid & in_ready;
    w_len_eff     = (len == '0) ? LEN_W'(1) : len;
    w_cnt_inc     = r_cnt + LEN_W'(1);
    unique case (r_state)
      S_IDLE: begin
        if (w_beat) begin
          w_len_nxt = w_len_eff;
          w_acc_nxt = w_sat_val;
          w_ovf_nxt = w_sat_flag;
          w_cnt_nxt = LEN_W'(1);
          if (w_len_eff == LEN_W'(1)) begin
            w_state_nxt   = S_HOLD;
            w_out_acc_nxt = w_sat_val;
            w_out_ovf_nxt = w_sat_flag;
          end else begin
            w_state_nxt = S_ACCUM;
          end
        end
      end
      S_ACCUM: begin
        if (w_beat) begin
          w_acc_nxt = w_sat_val;
          w_ovf_nxt = r_ovf | w_sat_flag;
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == r_len) begin
            w_state_nxt   = S_HOLD;
            w_out_acc_nxt = w_sat_val;
            w_out_ovf_nxt = r_ovf | w_sat_flag;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    out_acc = r_out_acc;
    out_ovf = r_out_ovf;
  end

  // State and datapath registers; reset drops any partial frame at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_len     <= '0;
      r_ovf     <= 1'b0;
      r_out_acc <= '0;
      r_out_ovf <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_acc     <= w_acc_nxt;
      r_cnt     <= w_cnt_nxt;
      r_len     <= w_len_nxt;
      r_ovf     <= w_ovf_nxt;
      r_out_acc <= w_out_acc_nxt;
      r_out_ovf <= w_out_ovf_nxt;
    end
  end

endmodule

// File: tb/tb_booth10_prod_accum.sv
// Directed bench for booth10_prod_accum: one task per scenario.
module tb_booth10_prod_accum;

  localparam int unsigned P_W   = 20;
  localparam int unsigned ACC_W = 24;
  localparam int unsigned LEN_W = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [P_W-1:0]   in_p;
  logic [LEN_W-1:0] len;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;
  logic             busy;

  int unsigned n_pass;
  int unsigned n_total;

  booth10_prod_accum #(
    .P_W  (P_W),
    .ACC_W(ACC_W),
    .LEN_W(LEN_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_p     (in_p),
    .len      (len),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_acc  (out_acc),
    .out_ovf  (out_ovf),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one beat and returns 1 time unit after the edge that took it.
  task automatic send(input logic [P_W-1:0] p, input logic [LEN_W-1:0] l);
    int unsigned n;
    in_valid = 1'b1;
    in_p     = p;
    len      = l;
    n        = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_p     = 'x;
  endtask

  // Completes a result handshake and checks that out_valid drops.
  task automatic drain(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_total++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s_drain: out_valid=%0b busy=%0b required 0 0", name, out_valid, busy);
    else n_pass++;
  endtask

  task automatic check_result(input string name, input logic [ACC_W-1:0] acc,
                              input logic ovf);
    n_total++;
    if (out_valid !== 1'b1 || out_acc !== acc || out_ovf !== ovf)
      $display("FAIL %s: out_valid=%0b out_acc=%h out_ovf=%0b required 1 %h %0b",
               name, out_valid, out_acc, out_ovf, acc, ovf);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_p = '0; len = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (out_valid !== 1'b0 || out_acc !== '0 || out_ovf !== 1'b0 ||
        busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL reset: v=%0b acc=%h ovf=%0b busy=%0b rdy=%0b required 0 0 0 0 1",
               out_valid, out_acc, out_ovf, busy, in_ready);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send(20'd100, 8'd3);
    send(-20'sd50, 8'd3);
    n_total++;
    if (out_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL basic_mid: out_valid=%0b busy=%0b required 0 1", out_valid, busy);
    else n_pass++;
    send(20'd7, 8'd3);
    check_result("basic", 24'd57, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_acc !== 24'd57)
      $display("FAIL basic_after: v=%0b busy=%0b acc=%h required 0 0 %h",
               out_valid, busy, out_acc, 24'd57);
    else n_pass++;
  endtask

  task automatic test_pos_sat();
    for (int i = 0; i < 16; i++) send(20'h7FFFF, 8'd17);
    n_total++;
    if (out_valid !== 1'b0)
      $display("FAIL pos_sat_16: out_valid=%0b required 0", out_valid);
    else n_pass++;
    send(20'h7FFFF, 8'd17);
    check_result("pos_sat", 24'h7FFFFF, 1'b1);
    drain("pos_sat");
  endtask

  task automatic test_neg_boundary();
    for (int i = 0; i < 16; i++) send(20'h80000, 8'd16);
    check_result("neg_exact", 24'h800000, 1'b0);
    drain("neg_exact");
    for (int i = 0; i < 17; i++) send(20'h80000, 8'd17);
    check_result("neg_sat", 24'h800000, 1'b1);
    drain("neg_sat");
  endtask

  task automatic test_back_to_back();
    send(20'd5, 8'd2);
    send(20'd6, 8'd2);
    in_valid = 1'b1; in_p = 20'd1; len = 8'd1;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (out_valid !== 1'b1 || out_acc !== 24'd11 || in_ready !== 1'b0)
        $display("FAIL backpressure_%0d: v=%0b acc=%h rdy=%0b required 1 %h 0",
                 i, out_valid, out_acc, in_ready, 24'd11);
      else n_pass++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_release: v=%0b busy=%0b rdy=%0b required 0 0 1",
               out_valid, busy, in_ready);
    else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0; in_p = 'x;
    check_result("bp_next_frame", 24'd1, 1'b0);
    drain("bp_next_frame");
  endtask

  task automatic test_len0_gaps();
    send(-20'sd9, 8'd0);
    check_result("len0", 24'hFFFFF7, 1'b0);
    drain("len0");
    // valid pattern 1,0,1,0,1,1 carrying beats 1..4; len changed after beat 1
    in_valid = 1'b1; in_p = 20'd1; len = 8'd4;
    @(posedge clk); #1;
    len = 8'd1;
    in_valid = 1'b0; in_p = 'x;
    @(posedge clk); #1;
    in_valid = 1'b1; in_p = 20'd2;
    @(posedge clk); #1;
    in_valid = 1'b0; in_p = 'x;
    @(posedge clk); #1;
    in_valid = 1'b1; in_p = 20'd3;
    @(posedge clk); #1;
    n_total++;
    if (out_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL gaps_mid: out_valid=%0b busy=%0b required 0 1", out_valid, busy);
    else n_pass++;
    in_p = 20'd4;
    @(posedge clk); #1;
    in_valid = 1'b0; in_p = 'x;
    check_result("gaps", 24'd10, 1'b0);
    drain("gaps");
  endtask

  task automatic test_reset_mid();
    send(20'd1, 8'd4);
    send(20'd2, 8'd4);
    rst_n = 1'b0;
    #1;
    n_total++;
    if (out_valid !== 1'b0 || out_acc !== '0 || out_ovf !== 1'b0 ||
        busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL reset_mid: v=%0b acc=%h ovf=%0b busy=%0b rdy=%0b required 0 0 0 0 1",
               out_valid, out_acc, out_ovf, busy, in_ready);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(20'd3, 8'd1);
    check_result("after_reset", 24'd3, 1'b0);
    drain("after_reset");
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_basic();
    test_pos_sat();
    test_neg_boundary();
    test_back_to_back();
    test_len0_gaps();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
